// File: rtl/inference_sequencer_pkg.sv
// Shared types and default sizing for the inference sequencer.
package inference_sequencer_pkg;

  localparam int DEF_DATA_W  = 19;
  localparam int DEF_DEPTH   = 128;
  localparam int DEF_ADDR_W  = 7;
  localparam int DEF_NET_LAT = 9;
  localparam int DEF_RES_W   = 7;
  localparam int DEF_TMO_W   = 12;
  localparam int FRAME_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RUN      = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_WAIT_RES = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERR      = 3'd6
  } state_e;

endpackage

// File: rtl/inference_sequencer_seq_counter.sv
// Loadable up-counter with a terminal-count flag compared against a runtime value.
module seq_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  logic [W-1:0] count_q, count_d;

  // Next count: load wins over increment, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == term_i);

endmodule

// File: rtl/inference_sequencer.sv
// Command-driven LOAD/RUN sequencer for the memory -> network -> output layer path.
module inference_sequencer
  import inference_sequencer_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NET_LAT = DEF_NET_LAT,
  parameter int RES_W   = DEF_RES_W,
  parameter int TMO_W   = DEF_TMO_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_load,
  input  logic               cmd_run,
  input  logic               cmd_abort,
  input  logic               din_valid,
  input  logic [DATA_W-1:0]  din,
  output logic               din_ready,
  output logic               mem_write_en,
  output logic               mem_read_en,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               res_valid_i,
  input  logic [RES_W-1:0]   res_i,
  output logic               result_valid_o,
  output logic [RES_W-1:0]   result_o,
  output logic               busy,
  output logic               timeout_o,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [TMO_W-1:0]  DRAIN_LAST = TMO_W'(NET_LAT - 1);
  // WAIT_RES gives up on the cycle whose increment would make the counter all-ones.
  localparam logic [TMO_W-1:0]  TMO_LAST   = {{(TMO_W-1){1'b1}}, 1'b0};

  state_e state_q, state_d;

  logic              addr_clr, addr_en, addr_tc;
  logic              cnt_clr, cnt_en, cnt_tc;
  logic [TMO_W-1:0]  cnt_term, cnt_val;
  logic              accept_res;
  logic              wr_en;

  logic              read_en_q, busy_q, timeout_q, result_valid_q;
  logic [RES_W-1:0]  result_q;
  logic [FRAME_W-1:0] frame_cnt_q;

  // Frame address: runs 0..DEPTH-1 within a phase, cleared at phase boundaries.
  seq_counter #(.W(ADDR_W)) u_addr_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (addr_clr),
    .load_val_i ('0),
    .en_i       (addr_en),
    .term_i     (ADDR_LAST),
    .count_o    (mem_addr),
    .tc_o       (addr_tc)
  );

  // DRAIN and WAIT_RES never overlap, so one counter times both.
  seq_counter #(.W(TMO_W)) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_clr),
    .load_val_i ('0),
    .en_i       (cnt_en),
    .term_i     (cnt_term),
    .count_o    (cnt_val),
    .tc_o       (cnt_tc)
  );

  // Next-state, counter control and write strobe decode.
  always_comb begin
    state_d    = state_q;
    addr_clr   = 1'b0;
    addr_en    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    accept_res = 1'b0;
    wr_en      = 1'b0;
    cnt_term   = (state_q == ST_DRAIN) ? DRAIN_LAST : TMO_LAST;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (cmd_load) begin
          state_d  = ST_LOAD;
          addr_clr = 1'b1;
          cnt_clr  = 1'b1;
        end else if (cmd_run) begin
          state_d  = ST_RUN;
          addr_clr = 1'b1;
          cnt_clr  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (din_valid) begin
          wr_en = 1'b1;
          if (addr_tc) begin
            state_d  = ST_DONE;
            addr_clr = 1'b1;
          end else begin
            addr_en = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (addr_tc) begin
          state_d  = ST_DRAIN;
          addr_clr = 1'b1;
        end else begin
          addr_en = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_tc) begin
          state_d = ST_WAIT_RES;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_WAIT_RES: begin
        if (res_valid_i) begin
          accept_res = 1'b1;
          state_d    = ST_DONE;
          cnt_clr    = 1'b1;
        end else if (cnt_tc) begin
          state_d = ST_ERR;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (cmd_abort) begin
      state_d    = ST_IDLE;
      addr_clr   = 1'b1;
      addr_en    = 1'b0;
      cnt_clr    = 1'b1;
      cnt_en     = 1'b0;
      accept_res = 1'b0;
      wr_en      = 1'b0;
    end
  end

  // State, registered status outputs and the result latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      read_en_q      <= 1'b0;
      busy_q         <= 1'b0;
      timeout_q      <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      frame_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      read_en_q      <= (state_d == ST_RUN);
      busy_q         <= !(state_d inside {ST_IDLE, ST_DONE, ST_ERR});
      timeout_q      <= (state_d == ST_ERR);
      result_valid_q <= accept_res;
      if (accept_res) begin
        result_q    <= res_i;
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  // Write strobe, data and ready are decoded so the memory sees address, data and
  // strobe of the same handshake in the same cycle.
  assign din_ready      = (state_q == ST_LOAD) && !cmd_abort;
  assign mem_write_en   = wr_en;
  assign mem_wdata      = wr_en ? din : '0;
  assign mem_read_en    = read_en_q;
  assign busy           = busy_q;
  assign timeout_o      = timeout_q;
  assign result_valid_o = result_valid_q;
  assign result_o       = result_q;
  assign frame_cnt      = frame_cnt_q;

endmodule
